// File: rtl/dp_dap_gen.sv
// JTAG debug access port: 1149.1 TAP, IR, BYPASS, optional IDCODE and N_DR user DRs.
// Define DP_DAP_IDCODE_EN to include IDCODE (opcode 1, also the reset opcode).
module dp_dap_gen #(
    parameter int unsigned     IR_W       = 5,
    parameter int unsigned     DR_W       = 32,
    parameter int unsigned     N_DR       = 4,
    parameter logic [31:0]     IDCODE_VAL = 32'h1000_0003,
    parameter logic [IR_W-1:0] USER_BASE  = IR_W'(8)
) (
    input  logic                 tck,
    input  logic                 trst,
    input  logic                 tms,
    input  logic                 tdi,
    output logic                 tdo,
    output logic                 tdo_en,
    output logic [3:0]           state_out,
    output logic [IR_W-1:0]      ir_out,
    input  logic [N_DR*DR_W-1:0] dr_cap,
    output logic [N_DR*DR_W-1:0] dr_upd,
    output logic [N_DR-1:0]      dr_upd_vld
);

    localparam int unsigned SH_W = (DR_W > 32) ? DR_W : 32;
`ifdef DP_DAP_IDCODE_EN
    localparam logic [IR_W-1:0] RST_OP = IR_W'(1);
`else
    localparam logic [IR_W-1:0] RST_OP = '1;
`endif

    if (IR_W < 2 || DR_W < 1 || N_DR < 1 || N_DR > 16 || IDCODE_VAL[0] != 1'b1) begin : g_param_check
        $error("dp_dap_gen: illegal parameter combination");
    end

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PA_DR  = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PA_IR  = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    typedef enum logic [1:0] {SEL_BYPASS, SEL_IDCODE, SEL_USER} dr_sel_e;

    tap_state_e            state_q, state_d;
    logic [IR_W-1:0]       ir_q, ir_d;
    logic [IR_W-1:0]       ir_sh_q, ir_sh_d;
    logic [SH_W-1:0]       dr_sh_q, dr_sh_d;
    logic [N_DR*DR_W-1:0]  dr_upd_q, dr_upd_d;
    logic [N_DR-1:0]       dr_upd_vld_q, dr_upd_vld_d;
    dr_sel_e               sel;
    int unsigned           sel_idx;
    int unsigned           sh_len;

    always_ff @(posedge tck) begin
        if (trst) begin
            state_q      <= TLR;
            ir_q         <= RST_OP;
            ir_sh_q      <= '0;
            dr_sh_q      <= '0;
            dr_upd_q     <= '0;
            dr_upd_vld_q <= '0;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            ir_sh_q      <= ir_sh_d;
            dr_sh_q      <= dr_sh_d;
            dr_upd_q     <= dr_upd_d;
            dr_upd_vld_q <= dr_upd_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:     state_d = tms ? TLR    : RTI;
            RTI:     state_d = tms ? SEL_DR : RTI;
            SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms ? UPD_DR : PA_DR;
            PA_DR:   state_d = tms ? EX2_DR : PA_DR;
            EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms ? SEL_DR : RTI;
            SEL_IR:  state_d = tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms ? UPD_IR : PA_IR;
            PA_IR:   state_d = tms ? EX2_IR : PA_IR;
            EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        sel     = SEL_BYPASS;
        sel_idx = 0;
        sh_len  = 1;
        if (ir_q != '1) begin
`ifdef DP_DAP_IDCODE_EN
            if (ir_q == IR_W'(1)) begin
                sel    = SEL_IDCODE;
                sh_len = 32;
            end
`endif
            for (int unsigned k = 0; k < N_DR; k++) begin
                if (ir_q == USER_BASE + IR_W'(k)) begin
                    sel     = SEL_USER;
                    sel_idx = k;
                    sh_len  = DR_W;
                end
            end
        end
    end

    always_comb begin
        ir_d         = ir_q;
        ir_sh_d      = ir_sh_q;
        dr_sh_d      = dr_sh_q;
        dr_upd_d     = dr_upd_q;
        dr_upd_vld_d = '0;
        case (state_q)
            CAP_IR: ir_sh_d = IR_W'(2'b01);
            SH_IR:  ir_sh_d = {tdi, ir_sh_q[IR_W-1:1]};
            UPD_IR: ir_d    = ir_sh_q;
            CAP_DR: begin
                dr_sh_d = '0;
`ifdef DP_DAP_IDCODE_EN
                if (sel == SEL_IDCODE) dr_sh_d = SH_W'(IDCODE_VAL);
`endif
                for (int unsigned k = 0; k < N_DR; k++) begin
                    if (sel == SEL_USER && sel_idx == k) dr_sh_d = SH_W'(dr_cap[k*DR_W +: DR_W]);
                end
            end
            SH_DR: begin
                // tdi lands at the top of the selected length; bits above it are don't-care
                dr_sh_d = dr_sh_q >> 1;
                for (int unsigned i = 0; i < SH_W; i++) begin
                    if (i == sh_len - 1) dr_sh_d[i] = tdi;
                end
            end
            UPD_DR: begin
                for (int unsigned k = 0; k < N_DR; k++) begin
                    if (sel == SEL_USER && sel_idx == k) begin
                        dr_upd_d[k*DR_W +: DR_W] = dr_sh_q[DR_W-1:0];
                        dr_upd_vld_d[k]          = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (state_d == TLR) ir_d = RST_OP;
    end

    always_comb begin
        tdo    = 1'b0;
        tdo_en = 1'b0;
        case (state_q)
            SH_DR: begin
                tdo    = dr_sh_q[0];
                tdo_en = 1'b1;
            end
            SH_IR: begin
                tdo    = ir_sh_q[0];
                tdo_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_out  = state_q;
    assign ir_out     = ir_q;
    assign dr_upd     = dr_upd_q;
    assign dr_upd_vld = dr_upd_vld_q;

endmodule
